// File: rtl/traffic_light_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
//   Shared definitions for the two-road intersection controller:
//   - 3-bit state encoding (also exported on state_o for debug)
//   - bit positions inside the packed lamp vector
//   - lamp_decode(): Moore lamp pattern for a given state and flash phase
// -----------------------------------------------------------------------------
package traffic_light_pkg;

    // State encoding, fixed so that state_o is stable for debug tools.
    localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] S_ALLRED_A    = 3'd2;
    localparam logic [2:0] S_SIDE_GREEN  = 3'd3;
    localparam logic [2:0] S_SIDE_YELLOW = 3'd4;
    localparam logic [2:0] S_ALLRED_B    = 3'd5;
    localparam logic [2:0] S_FLASH       = 3'd6;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = S_MAIN_GREEN,
        ST_MAIN_YELLOW = S_MAIN_YELLOW,
        ST_ALLRED_A    = S_ALLRED_A,
        ST_SIDE_GREEN  = S_SIDE_GREEN,
        ST_SIDE_YELLOW = S_SIDE_YELLOW,
        ST_ALLRED_B    = S_ALLRED_B,
        ST_FLASH       = S_FLASH
    } state_t;

    // Lamp vector bit positions.
    localparam int LAMP_W           = 7;
    localparam int LAMP_MAIN_RED    = 6;
    localparam int LAMP_MAIN_YELLOW = 5;
    localparam int LAMP_MAIN_GREEN  = 4;
    localparam int LAMP_SIDE_RED    = 3;
    localparam int LAMP_SIDE_YELLOW = 2;
    localparam int LAMP_SIDE_GREEN  = 1;
    localparam int LAMP_WALK        = 0;

    // Moore lamp pattern. The unreachable encoding shows all-red so that a
    // corrupted state never lights a green lamp.
    function automatic logic [LAMP_W-1:0] lamp_decode(input state_t st, input logic phase);
        logic [LAMP_W-1:0] l;
        l = '0;
        case (st)
            ST_MAIN_GREEN: begin
                l[LAMP_MAIN_GREEN] = 1'b1;
                l[LAMP_SIDE_RED]   = 1'b1;
            end
            ST_MAIN_YELLOW: begin
                l[LAMP_MAIN_YELLOW] = 1'b1;
                l[LAMP_SIDE_RED]    = 1'b1;
            end
            ST_SIDE_GREEN: begin
                l[LAMP_MAIN_RED]   = 1'b1;
                l[LAMP_SIDE_GREEN] = 1'b1;
                l[LAMP_WALK]       = 1'b1;
            end
            ST_SIDE_YELLOW: begin
                l[LAMP_MAIN_RED]    = 1'b1;
                l[LAMP_SIDE_YELLOW] = 1'b1;
            end
            ST_FLASH: begin
                l[LAMP_MAIN_YELLOW] = phase;
                l[LAMP_SIDE_RED]    = phase;
            end
            default: begin
                // ALLRED_A, ALLRED_B and the unused encoding
                l[LAMP_MAIN_RED] = 1'b1;
                l[LAMP_SIDE_RED] = 1'b1;
            end
        endcase
        return l;
    endfunction

    // Lamp pattern held while reset is asserted (all-red).
    localparam logic [LAMP_W-1:0] RESET_LAMPS =
        (LAMP_W'(1) << LAMP_MAIN_RED) | (LAMP_W'(1) << LAMP_SIDE_RED);

endpackage

// File: rtl/tl_phase_timer.sv
// -----------------------------------------------------------------------------
// tl_phase_timer
//   Loadable down-counter that times each controller phase. It stops at zero
//   and relies on the controller reloading it, so it never wraps.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset (count <= RST_VAL)
//   load      in   load load_val on the next edge (wins over counting)
//   load_val  in   CNT_W-bit value to load
//   count     out  current counter value
//   done      out  count == 0
// -----------------------------------------------------------------------------
module tl_phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//   Two-road intersection controller. Cycles main and side road lamps through
//   green, yellow and all-red clearance phases, shortens the main green on a
//   latched pedestrian request, and supports a night flashing mode.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   ped_req      in   pedestrian button, synchronous, any pulse width
//   flash_en     in   night mode request, level
//   main_red     out  main road red lamp
//   main_yellow  out  main road yellow lamp
//   main_green   out  main road green lamp
//   side_red     out  side road red lamp
//   side_yellow  out  side road yellow lamp
//   side_green   out  side road green lamp
//   walk         out  pedestrian walk lamp (crossing the main road)
//   state_o      out  current state encoding
// -----------------------------------------------------------------------------
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int MAIN_GREEN_T = 10,
    parameter int SIDE_GREEN_T = 6,
    parameter int YELLOW_T     = 3,
    parameter int ALLRED_T     = 2,
    parameter int MIN_GREEN_T  = 4,
    parameter int FLASH_T      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic [2:0] state_o
);

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] MG_LOAD = CNT_W'(MAIN_GREEN_T - 1);
    localparam logic [CNT_W-1:0] SG_LOAD = CNT_W'(SIDE_GREEN_T - 1);
    localparam logic [CNT_W-1:0] YL_LOAD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLASH_T - 1);

    // elapsed >= MIN_GREEN_T-1 with elapsed = MAIN_GREEN_T-1-timer is the
    // same as timer <= MAIN_GREEN_T-MIN_GREEN_T, which avoids a subtractor.
    localparam logic [CNT_W-1:0] CUT_MAX = CNT_W'(MAIN_GREEN_T - MIN_GREEN_T);

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic              ped_q, ped_d;
    logic              ped_any;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_load_val;
    logic [CNT_W-1:0]  tmr_count;
    logic              tmr_done;
    logic [LAMP_W-1:0] lamps_q, lamps_d;

    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (AR_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // Next-state, timer reload and pedestrian latch logic.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        // A request arriving on this very edge already counts, so a press
        // late in the main green ends it on that edge.
        ped_any      = ped_q | ped_req;

        if (flash_en) begin
            if (state_q != ST_FLASH) begin
                state_d      = ST_FLASH;
                phase_d      = 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = FL_LOAD;
            end else if (tmr_done) begin
                phase_d      = ~phase_q;
                tmr_load     = 1'b1;
                tmr_load_val = FL_LOAD;
            end
        end else begin
            case (state_q)
                ST_MAIN_GREEN: begin
                    if (tmr_done || (ped_any && (tmr_count <= CUT_MAX))) begin
                        state_d      = ST_MAIN_YELLOW;
                        tmr_load     = 1'b1;
                        tmr_load_val = YL_LOAD;
                    end
                end
                ST_MAIN_YELLOW: begin
                    if (tmr_done) begin
                        state_d      = ST_ALLRED_A;
                        tmr_load     = 1'b1;
                        tmr_load_val = AR_LOAD;
                    end
                end
                ST_ALLRED_A: begin
                    if (tmr_done) begin
                        state_d      = ST_SIDE_GREEN;
                        tmr_load     = 1'b1;
                        tmr_load_val = SG_LOAD;
                    end
                end
                ST_SIDE_GREEN: begin
                    if (tmr_done) begin
                        state_d      = ST_SIDE_YELLOW;
                        tmr_load     = 1'b1;
                        tmr_load_val = YL_LOAD;
                    end
                end
                ST_SIDE_YELLOW: begin
                    if (tmr_done) begin
                        state_d      = ST_ALLRED_B;
                        tmr_load     = 1'b1;
                        tmr_load_val = AR_LOAD;
                    end
                end
                ST_ALLRED_B: begin
                    if (tmr_done) begin
                        state_d      = ST_MAIN_GREEN;
                        tmr_load     = 1'b1;
                        tmr_load_val = MG_LOAD;
                    end
                end
                default: begin
                    // Leaving FLASH, or recovering from the unused encoding:
                    // always pass through a full all-red clearance.
                    state_d      = ST_ALLRED_B;
                    tmr_load     = 1'b1;
                    tmr_load_val = AR_LOAD;
                end
            endcase
        end

        // Entering SIDE_GREEN serves the crossing; a press on the same edge
        // is considered served too.
        if ((state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN)) begin
            ped_d = 1'b0;
        end else begin
            ped_d = ped_any;
        end

        lamps_d = lamp_decode(state_d, phase_d);
    end

    // Lamps are registered from the next-state decode so they always match
    // state_q; reset forces all-red without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ALLRED_B;
            phase_q <= 1'b1;
            ped_q   <= 1'b0;
            lamps_q <= RESET_LAMPS;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ped_q   <= ped_d;
            lamps_q <= lamps_d;
        end
    end

    assign main_red    = lamps_q[LAMP_MAIN_RED];
    assign main_yellow = lamps_q[LAMP_MAIN_YELLOW];
    assign main_green  = lamps_q[LAMP_MAIN_GREEN];
    assign side_red    = lamps_q[LAMP_SIDE_RED];
    assign side_yellow = lamps_q[LAMP_SIDE_YELLOW];
    assign side_green  = lamps_q[LAMP_SIDE_GREEN];
    assign walk        = lamps_q[LAMP_WALK];
    assign state_o     = state_q;

endmodule
